reflet_periph_arbiter: RTL and testbench

//  Shares the memory-mapped peripheral register bus (hardware info, GPIO, timer, UART, PWM, EXTI

---
 rtl/reflet_periph_arbiter_pkg.sv | 18 +
 rtl/reflet_rr_burst_pick.sv | 32 +++
 rtl/reflet_periph_arbiter.sv | 112 +++++++++++
 tb/tb_reflet_periph_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reflet_periph_arbiter_pkg.sv
// Shared encodings for the peripheral bus arbiter.
package reflet_periph_arbiter_pkg;

    // 2'd3 is never entered; the FSM maps it back to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    function automatic int cnt_width(input int mb);
        return $clog2(mb + 1);
    endfunction

endpackage

// File: rtl/reflet_rr_burst_pick.sv
// Round-robin pick between two masters with a bounded burst length.
module reflet_rr_burst_pick
    import reflet_periph_arbiter_pkg::*;
#(
    parameter int CW = 3
) (
    input  logic [1:0]    req,
    input  logic          last_owner,
    input  logic [CW-1:0] burst_cnt,
    input  logic [CW-1:0] max_burst,
    output logic          grant_valid,
    output logic          grant_id,
    output logic          same_owner
);

    logic keep;

    always_comb begin
        // burst_cnt==0 only right after reset: nobody owns a burst yet,
        // so a tie goes to the master that is not last_owner (m0).
        keep        = (burst_cnt != '0) && (burst_cnt < max_burst);
        grant_valid = |req;
        case (req)
            2'b01:   grant_id = M0;
            2'b10:   grant_id = M1;
            2'b11:   grant_id = keep ? last_owner : ~last_owner;
            default: grant_id = M0;
        endcase
        same_owner = grant_valid && (grant_id == last_owner);
    end

endmodule

// File: rtl/reflet_periph_arbiter.sv
// Two-master arbiter for the memory-mapped peripheral register bus.
module reflet_periph_arbiter
    import reflet_periph_arbiter_pkg::*;
#(
    parameter int wordsize       = 16,
    parameter int base_addr_size = 16,
    parameter int max_burst      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      m0_req,
    input  logic                      m1_req,
    input  logic [base_addr_size-1:0] m0_addr,
    input  logic [base_addr_size-1:0] m1_addr,
    input  logic [wordsize-1:0]       m0_din,
    input  logic [wordsize-1:0]       m1_din,
    input  logic                      m0_we,
    input  logic                      m1_we,
    output logic [wordsize-1:0]       m0_dout,
    output logic [wordsize-1:0]       m1_dout,
    output logic                      m0_ready,
    output logic                      m1_ready,
    output logic                      periph_enable,
    output logic [base_addr_size-1:0] periph_addr,
    output logic [wordsize-1:0]       periph_din,
    output logic                      periph_we,
    input  logic [wordsize-1:0]       periph_dout
);

    localparam int CW = cnt_width(max_burst);
    localparam logic [CW-1:0] MAX_CNT = CW'(max_burst);

    state_t        state, state_nx;
    logic          owner, owner_nx;
    logic          last_owner;
    logic [CW-1:0] burst_cnt, burst_nx;

    logic grant_valid;
    logic grant_id;
    logic same_owner;

    reflet_rr_burst_pick #(
        .CW (CW)
    ) u_pick (
        .req         ({m1_req, m0_req}),
        .last_owner  (last_owner),
        .burst_cnt   (burst_cnt),
        .max_burst   (MAX_CNT),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .same_owner  (same_owner)
    );

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        burst_nx = burst_cnt;
        case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_nx = ST_ACCESS;
                    owner_nx = grant_id;
                    if (!same_owner)
                        burst_nx = CW'(1);
                    else if (burst_cnt != MAX_CNT)
                        burst_nx = burst_cnt + CW'(1);
                end
            end
            ST_ACCESS: state_nx = ST_ACK;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Bus side is gated to zero outside ACCESS so the OR-combined
    // peripheral bus sees nothing while idle.
    always_comb begin
        periph_enable = (state == ST_ACCESS);
        periph_addr   = '0;
        periph_din    = '0;
        periph_we     = 1'b0;
        if (periph_enable) begin
            periph_addr = (owner == M1) ? m1_addr : m0_addr;
            periph_din  = (owner == M1) ? m1_din  : m0_din;
            periph_we   = (owner == M1) ? m1_we   : m0_we;
        end
        m0_ready = (state == ST_ACK) && (owner == M0);
        m1_ready = (state == ST_ACK) && (owner == M1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            owner      <= M0;
            last_owner <= M1;
            burst_cnt  <= '0;
            m0_dout    <= '0;
            m1_dout    <= '0;
        end else begin
            state     <= state_nx;
            owner     <= owner_nx;
            burst_cnt <= burst_nx;
            if (state == ST_ACCESS) begin
                last_owner <= owner;
                if (owner == M1)
                    m1_dout <= periph_dout;
                else
                    m0_dout <= periph_dout;
            end
        end
    end

endmodule

// File: tb/tb_reflet_periph_arbiter.sv
// Bench: two arbiters (max_burst 4 and 1) checked against a transaction model.
module tb_reflet_periph_arbiter;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] din;
        logic        we;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mem_init;
    logic        req   [2][2];
    logic [15:0] addr  [2][2];
    logic [15:0] din   [2][2];
    logic        we    [2][2];
    logic [15:0] dout  [2][2];
    logic        rdy   [2][2];
    logic        pen   [2];
    logic [15:0] paddr [2];
    logic [15:0] pdin  [2];
    logic        pwe   [2];
    logic [15:0] pdout [2];

    function automatic logic [15:0] init_val(input int i);
        return 16'h5A00 ^ 16'(i * 259);
    endfunction

    for (genvar d = 0; d < 2; d++) begin : g_dut
        logic [15:0] mem [16];

        reflet_periph_arbiter #(
            .wordsize       (16),
            .base_addr_size (16),
            .max_burst      ((d == 0) ? 4 : 1)
        ) u_dut (
            .clk           (clk),
            .reset         (rst),
            .m0_req        (req[d][0]),
            .m1_req        (req[d][1]),
            .m0_addr       (addr[d][0]),
            .m1_addr       (addr[d][1]),
            .m0_din        (din[d][0]),
            .m1_din        (din[d][1]),
            .m0_we         (we[d][0]),
            .m1_we         (we[d][1]),
            .m0_dout       (dout[d][0]),
            .m1_dout       (dout[d][1]),
            .m0_ready      (rdy[d][0]),
            .m1_ready      (rdy[d][1]),
            .periph_enable (pen[d]),
            .periph_addr   (paddr[d]),
            .periph_din    (pdin[d]),
            .periph_we     (pwe[d]),
            .periph_dout   (pdout[d])
        );

        assign pdout[d] = pen[d] ? mem[paddr[d][3:0]] : 16'h0;

        always @(posedge clk) begin
            if (mem_init) begin
                for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
            end else if (pen[d] && pwe[d]) begin
                mem[paddr[d][3:0]] <= pdin[d];
            end
        end
    end

    // Reference model state
    int          n_assert = 0;
    int          n_fail   = 0;
    int          phase [2];
    int          ps    [2];
    logic        gown  [2];
    txn_t        cur   [2];
    logic [15:0] edout [2][2];
    bit          any_g [2];
    logic        lastm [2];
    int          run_n [2];
    int          glog  [2][128];
    int          gn    [2];
    logic [15:0] mm    [2][16];
    txn_t        qb    [2][2][64];
    int          qh    [2][2];
    int          qt    [2][2];

    function automatic int mbf(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic txn_t rnd_txn();
        txn_t t;
        t.addr = {12'hFF0, 4'($urandom_range(0, 15))};
        t.din  = 16'($urandom);
        t.we   = 1'($urandom);
        return t;
    endfunction

    task automatic push(input int m, input txn_t t);
        for (int d = 0; d < 2; d++) begin
            qb[d][m][qt[d][m] % 64] = t;
            qt[d][m]++;
        end
    endtask

    task automatic drive();
        txn_t t;
        for (int d = 0; d < 2; d++) begin
            for (int m = 0; m < 2; m++) begin
                if (qt[d][m] > qh[d][m]) begin
                    t = qb[d][m][qh[d][m] % 64];
                    req[d][m]  = 1'b1;
                    addr[d][m] = t.addr;
                    din[d][m]  = t.din;
                    we[d][m]   = t.we;
                end else begin
                    req[d][m]  = 1'b0;
                    addr[d][m] = 16'($urandom);
                    din[d][m]  = 16'($urandom);
                    we[d][m]   = 1'($urandom);
                end
            end
        end
    endtask

    function automatic bit idle_all();
        bit r = 1'b1;
        for (int d = 0; d < 2; d++) begin
            if (phase[d] != 0) r = 1'b0;
            for (int m = 0; m < 2; m++)
                if (qt[d][m] > qh[d][m]) r = 1'b0;
        end
        return r;
    endfunction

    task automatic reset_model(input bit init);
        for (int d = 0; d < 2; d++) begin
            phase[d] = 0;
            any_g[d] = 1'b0;
            lastm[d] = 1'b1;
            run_n[d] = 0;
            gn[d]    = 0;
            for (int m = 0; m < 2; m++) begin
                edout[d][m] = 16'h0;
                qh[d][m]    = 0;
                qt[d][m]    = 0;
            end
            if (init)
                for (int i = 0; i < 16; i++) mm[d][i] = init_val(i);
        end
    endtask

    task automatic chk_zero(input int d);
        chk($sformatf("rst_en d%0d", d), 32'(pen[d]), 0);
        chk($sformatf("rst_addr d%0d", d), 32'(paddr[d]), 0);
        chk($sformatf("rst_din d%0d", d), 32'(pdin[d]), 0);
        chk($sformatf("rst_we d%0d", d), 32'(pwe[d]), 0);
        chk($sformatf("rst_rdy0 d%0d", d), 32'(rdy[d][0]), 0);
        chk($sformatf("rst_rdy1 d%0d", d), 32'(rdy[d][1]), 0);
        chk($sformatf("rst_dout0 d%0d", d), 32'(dout[d][0]), 0);
        chk($sformatf("rst_dout1 d%0d", d), 32'(dout[d][1]), 0);
    endtask

    task automatic do_reset(input bit init);
        rst      = 1'b1;
        mem_init = init;
        reset_model(init);
        drive();
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) chk_zero(d);
        @(posedge clk); #1;
        rst      = 1'b0;
        mem_init = 1'b0;
    endtask

    task automatic check_cycle(input int d);
        chk($sformatf("both_rdy d%0d", d), 32'(rdy[d][0] & rdy[d][1]), 0);
        case (phase[d])
            1: begin
                chk($sformatf("acc_en d%0d", d), 32'(pen[d]), 1);
                chk($sformatf("acc_addr d%0d", d), 32'(paddr[d]), 32'(cur[d].addr));
                chk($sformatf("acc_din d%0d", d), 32'(pdin[d]), 32'(cur[d].din));
                chk($sformatf("acc_we d%0d", d), 32'(pwe[d]), 32'(cur[d].we));
                chk($sformatf("acc_rdy d%0d", d), 32'(rdy[d][0] | rdy[d][1]), 0);
            end
            2: begin
                chk($sformatf("ack_en d%0d", d), 32'(pen[d]), 0);
                chk($sformatf("ack_rdy_own d%0d", d), 32'(rdy[d][gown[d]]), 1);
                chk($sformatf("ack_rdy_oth d%0d", d), 32'(rdy[d][!gown[d]]), 0);
            end
            default: begin
                chk($sformatf("idle_en d%0d", d), 32'(pen[d]), 0);
                chk($sformatf("idle_bus d%0d", d), 32'(paddr[d] | pdin[d]), 0);
                chk($sformatf("idle_we d%0d", d), 32'(pwe[d]), 0);
                chk($sformatf("idle_rdy d%0d", d), 32'(rdy[d][0] | rdy[d][1]), 0);
            end
        endcase
        chk($sformatf("dout0 d%0d", d), 32'(dout[d][0]), 32'(edout[d][0]));
        chk($sformatf("dout1 d%0d", d), 32'(dout[d][1]), 32'(edout[d][1]));
    endtask

    task automatic decide(input int d);
        bit   r0, r1;
        logic g;
        r0 = qt[d][0] > qh[d][0];
        r1 = qt[d][1] > qh[d][1];
        if (!r0 && !r1) return;
        if (r0 && r1)
            g = (any_g[d] && run_n[d] < mbf(d)) ? lastm[d] : !lastm[d];
        else
            g = r1;
        if (any_g[d] && g == lastm[d])
            run_n[d] = (run_n[d] < mbf(d)) ? run_n[d] + 1 : run_n[d];
        else
            run_n[d] = 1;
        any_g[d] = 1'b1;
        lastm[d] = g;
        gown[d]  = g;
        cur[d]   = qb[d][g][qh[d][g] % 64];
        phase[d] = 1;
        if (gn[d] < 128) glog[d][gn[d]] = int'(g);
        gn[d]++;
    endtask

    task automatic step();
        logic [15:0] data;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            ps[d] = phase[d];
            check_cycle(d);
            if (ps[d] == 2) qh[d][gown[d]]++;
        end
        drive();
        for (int d = 0; d < 2; d++) begin
            if (ps[d] == 1) begin
                data = mm[d][cur[d].addr[3:0]];
                if (cur[d].we) mm[d][cur[d].addr[3:0]] = cur[d].din;
                edout[d][gown[d]] = data;
                phase[d] = 2;
            end else if (ps[d] == 2) begin
                phase[d] = 0;
            end else begin
                decide(d);
            end
        end
    endtask

    task automatic run(input int max);
        int n = 0;
        while (n < max && !idle_all()) begin
            step();
            n++;
        end
        chk("run_timeout", 32'(n < max), 1);
        step();
    endtask

    initial begin
        txn_t t;
        int   n;
        bit   pushed;
        rst      = 1'b1;
        mem_init = 1'b0;
        reset_model(1'b1);
        drive();

        // Test 1: reset mid-ACCESS aborts a write, then m0 read works
        do_reset(1'b1);
        t = '{addr: 16'hFF02, din: 16'hBEEF, we: 1'b1};
        push(0, t);
        step();
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++)
            chk($sformatf("t1_access_en d%0d", d), 32'(pen[d]), 1);
        #1 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) chk_zero(d);
        @(posedge clk); #1;
        rst = 1'b0;
        reset_model(1'b0);
        drive();
        t = '{addr: 16'hFF02, din: 16'h0, we: 1'b0};
        push(0, t);
        run(20);
        for (int d = 0; d < 2; d++)
            chk($sformatf("t1_read d%0d", d), 32'(dout[d][0]), 32'(init_val(2)));

        // Test 2: single-master write by m1, then read back by m0
        t = '{addr: 16'hFF10, din: 16'hA5A5, we: 1'b1};
        push(1, t);
        run(20);
        for (int d = 0; d < 2; d++)
            chk($sformatf("t2_m0_hold d%0d", d), 32'(dout[d][0]), 32'(init_val(2)));
        t = '{addr: 16'hFF10, din: 16'h0, we: 1'b0};
        push(0, t);
        run(20);
        for (int d = 0; d < 2; d++)
            chk($sformatf("t2_readback d%0d", d), 32'(dout[d][0]), 32'h0000A5A5);

        // Test 3: tie right after reset
        do_reset(1'b0);
        push(0, rnd_txn());
        push(1, rnd_txn());
        run(40);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("t3_first d%0d", d), 32'(glog[d][0]), 0);
            chk($sformatf("t3_second d%0d", d), 32'(glog[d][1]), 1);
        end

        // Tests 4/6: continuous contention, burst 4 vs strict alternation
        do_reset(1'b0);
        for (int i = 0; i < 8; i++) begin
            push(0, rnd_txn());
            push(1, rnd_txn());
        end
        run(200);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("t4_count d%0d", d), 32'(gn[d]), 16);
            for (int i = 0; i < 16; i++)
                chk($sformatf("t4_order d%0d i%0d", d, i), 32'(glog[d][i]),
                    32'((d == 0) ? (i / 4) % 2 : i % 2));
        end

        // Test 5: uncontended burst, m1 arrives during the 6th access
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) push(0, rnd_txn());
        n = 0;
        pushed = 1'b0;
        while (n < 200 && !idle_all()) begin
            step();
            n++;
            if (!pushed && gn[0] == 6) begin
                push(1, rnd_txn());
                pushed = 1'b1;
            end
        end
        chk("t5_timeout", 32'(n < 200), 1);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("t5_count d%0d", d), 32'(gn[d]), 11);
            for (int i = 0; i < 11; i++)
                chk($sformatf("t5_order d%0d i%0d", d, i), 32'(glog[d][i]),
                    32'(i == 6));
        end

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            for (int m = 0; m < 2; m++)
                if ($urandom_range(0, 3) == 0 && qt[0][m] - qh[0][m] < 4)
                    push(m, rnd_txn());
            step();
        end
        run(200);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
